datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_if.sv | 61 ++++++
 rtl/datapath.sv | 143 ++++++++++++++
 tb/tb_datapath.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_if.sv
// ---------------------------------------------------------------------------
// datapath_if: control and observation bundle of the 16-bit multi-cycle datapath.
//
// There is no valid/ready handshake on this bundle. The controller (or a bench)
// drives every control as a level for the cycle it applies to. The datapath
// samples those levels on the next rising clk edge.
//
//   master : drives the controls and the memory-load port, observes the datapath
//   slave  : the datapath itself
//
// Controls : Buff_MEMIns, Buff_PC, Buff_PSW, MEMresource, WE_MEM, RBresource,
//            oprandB, LI, ALUorNot, LIorMOV, WBresource, PCplus1orWB, WE_RF,
//            ALUop, Flag, Branch, Jump[1:0]
// Load port: TBorNot, Tb_MEMWE, Tb_MEMAddr[7:0], Tb_MEMData[15:0]
// Observe  : OutR, PSW_NZC, opcode, ALUopcode, OutM, OutPC, OutNextPC
// ---------------------------------------------------------------------------
interface datapath_if;
    logic        Buff_MEMIns;
    logic        Buff_PC;
    logic        Buff_PSW;
    logic        MEMresource;
    logic        WE_MEM;
    logic        RBresource;
    logic        oprandB;
    logic        LI;
    logic        ALUorNot;
    logic        LIorMOV;
    logic        WBresource;
    logic        PCplus1orWB;
    logic        WE_RF;
    logic        ALUop;
    logic        Flag;
    logic        Branch;
    logic [1:0]  Jump;
    logic        TBorNot;
    logic        Tb_MEMWE;
    logic [7:0]  Tb_MEMAddr;
    logic [15:0] Tb_MEMData;

    logic [15:0] OutR;
    logic [2:0]  PSW_NZC;
    logic [4:0]  opcode;
    logic [1:0]  ALUopcode;
    logic [15:0] OutM;
    logic [15:0] OutPC;
    logic [15:0] OutNextPC;

    modport master (
        output Buff_MEMIns, Buff_PC, Buff_PSW, MEMresource, WE_MEM, RBresource,
               oprandB, LI, ALUorNot, LIorMOV, WBresource, PCplus1orWB, WE_RF,
               ALUop, Flag, Branch, Jump, TBorNot, Tb_MEMWE, Tb_MEMAddr, Tb_MEMData,
        input  OutR, PSW_NZC, opcode, ALUopcode, OutM, OutPC, OutNextPC
    );

    modport slave (
        input  Buff_MEMIns, Buff_PC, Buff_PSW, MEMresource, WE_MEM, RBresource,
               oprandB, LI, ALUorNot, LIorMOV, WBresource, PCplus1orWB, WE_RF,
               ALUop, Flag, Branch, Jump, TBorNot, Tb_MEMWE, Tb_MEMAddr, Tb_MEMData,
        output OutR, PSW_NZC, opcode, ALUopcode, OutM, OutPC, OutNextPC
    );
endinterface

// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath: 16-bit multi-cycle datapath with 8 registers and a 256x16 unified
// instruction/data memory. Sequencing is left to an external controller; this
// block holds no state machine.
//
// Ports:
//   clk  : sole clock, rising edge
//   Rst  : synchronous active-high reset (clears all state except memory)
//   bus  : datapath_if.slave -- controls in, observation outputs out
// ---------------------------------------------------------------------------
module datapath (
    input  logic       clk,
    input  logic       Rst,
    datapath_if.slave  bus
);

    logic [15:0] mem [256];
    logic [15:0] rf  [8];

    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] li_q;
    logic [15:0] alu_q;
    logic [15:0] mdr_q;
    logic [15:0] res_q;
    logic [2:0]  psw_q;     // {N, Z, C}

    logic [2:0]  rb_addr;
    logic [15:0] port_a;
    logic [15:0] port_b;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] b_next;
    logic [15:0] li_val;
    logic [15:0] b_op;
    logic        alu_cin;
    logic [16:0] alu_sum;
    logic [15:0] alu_res;
    logic [2:0]  alu_nzc;
    logic [15:0] res_next;
    logic [15:0] pc_plus1;
    logic [15:0] wb_data;
    logic [15:0] next_pc;

    // Register file reads are combinational; port A always uses IR[7:5].
    assign rb_addr = bus.RBresource ? ir_q[10:8] : ir_q[4:2];
    assign port_a  = rf[ir_q[7:5]];
    assign port_b  = rf[rb_addr];

    // The bench load port takes over the memory completely while TBorNot is high.
    assign mem_addr  = bus.TBorNot ? bus.Tb_MEMAddr
                                   : (bus.MEMresource ? alu_q[7:0] : pc_q[7:0]);
    assign mem_we    = bus.TBorNot ? bus.Tb_MEMWE   : bus.WE_MEM;
    assign mem_wdata = bus.TBorNot ? bus.Tb_MEMData : port_b;
    assign mem_rdata = mem[mem_addr];

    assign b_next = bus.oprandB ? {{11{ir_q[4]}}, ir_q[4:0]} : port_b;
    assign li_val = bus.LI ? {ir_q[7:0], port_b[7:0]} : {8'h00, ir_q[7:0]};

    // Subtract is A + ~B + cin. With Flag clear the carry-in defaults to 1 for
    // subtract, so the carry-out reads as "no borrow".
    always_comb begin
        b_op    = bus.ALUop ? ~b_q : b_q;
        alu_cin = bus.Flag ? psw_q[0] : bus.ALUop;
        alu_sum = {1'b0, a_q} + {1'b0, b_op} + {16'h0000, alu_cin};
    end

    assign alu_res = alu_sum[15:0];
    assign alu_nzc = {alu_res[15], (alu_res == 16'h0000), alu_sum[16]};

    assign res_next = !bus.ALUorNot ? alu_q : (bus.LIorMOV ? a_q : li_q);
    assign pc_plus1 = pc_q + 16'd1;
    assign wb_data  = bus.WBresource ? mdr_q : (bus.PCplus1orWB ? res_q : pc_plus1);

    // Branch takes priority over Jump; Jump 11 falls back to sequential.
    always_comb begin
        next_pc = pc_plus1;
        if (bus.Branch) begin
            next_pc = pc_q + {{8{ir_q[7]}}, ir_q[7:0]};
        end else begin
            case (bus.Jump)
                2'b01:   next_pc = pc_q + {{5{ir_q[10]}}, ir_q[10:0]};
                2'b10:   next_pc = a_q;
                default: next_pc = pc_plus1;
            endcase
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            pc_q  <= '0;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            li_q  <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            res_q <= '0;
            psw_q <= '0;
        end else begin
            // Pipeline latches reload every cycle; only IR, PC and PSW are gated.
            a_q   <= port_a;
            b_q   <= b_next;
            li_q  <= li_val;
            alu_q <= alu_res;
            mdr_q <= mem_rdata;
            res_q <= res_next;
            if (bus.Buff_MEMIns) ir_q  <= mem_rdata;
            if (bus.Buff_PC)     pc_q  <= next_pc;
            if (bus.Buff_PSW)    psw_q <= alu_nzc;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.WE_RF) begin
            rf[ir_q[10:8]] <= wb_data;
        end
    end

    assign bus.OutR      = port_a;
    assign bus.PSW_NZC   = psw_q;
    assign bus.opcode    = ir_q[15:11];
    assign bus.ALUopcode = ir_q[1:0];
    assign bus.OutM      = mem_rdata;
    assign bus.OutPC     = pc_q;
    assign bus.OutNextPC = next_pc;

endmodule

// File: tb/tb_datapath.sv
// ---------------------------------------------------------------------------
// tb_datapath: directed, table-driven bench for the datapath. Memory load and
// readback, next-PC selection and ALU results come from vector tables. The
// reset, register-clear and LLI/LDR/fetch program flows are hand sequences.
// ---------------------------------------------------------------------------
module tb_datapath;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } mem_vec_t;

    typedef struct {
        logic        branch;
        logic [1:0]  jump;
        logic [15:0] npc;
    } npc_vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic        flag;
        logic [15:0] res;
        logic [2:0]  nzc;
    } alu_vec_t;

    logic clk;
    logic Rst;
    int   checks;
    int   errors;

    mem_vec_t mem_tbl [5];
    npc_vec_t npc_tbl [6];
    alu_vec_t alu_tbl [8];

    datapath_if dif ();

    datapath dut (
        .clk (clk),
        .Rst (Rst),
        .bus (dif.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dif.Buff_MEMIns = 1'b0;
        dif.Buff_PC     = 1'b0;
        dif.Buff_PSW    = 1'b0;
        dif.MEMresource = 1'b0;
        dif.WE_MEM      = 1'b0;
        dif.RBresource  = 1'b0;
        dif.oprandB     = 1'b0;
        dif.LI          = 1'b0;
        dif.ALUorNot    = 1'b0;
        dif.LIorMOV     = 1'b0;
        dif.WBresource  = 1'b0;
        dif.PCplus1orWB = 1'b0;
        dif.WE_RF       = 1'b0;
        dif.ALUop       = 1'b0;
        dif.Flag        = 1'b0;
        dif.Branch      = 1'b0;
        dif.Jump        = 2'b00;
        dif.TBorNot     = 1'b0;
        dif.Tb_MEMWE    = 1'b0;
        dif.Tb_MEMAddr  = 8'h00;
        dif.Tb_MEMData  = 16'h0000;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (3) tick();
        Rst = 1'b0;
    endtask

    // Place a word at scratch address F0 through the load port, then fetch it
    // into IR. PC is left alone.
    task automatic load_ir(input logic [15:0] word);
        idle();
        dif.TBorNot    = 1'b1;
        dif.Tb_MEMAddr = 8'hF0;
        dif.Tb_MEMData = word;
        dif.Tb_MEMWE   = 1'b1;
        tick();
        dif.Tb_MEMWE    = 1'b0;
        dif.Buff_MEMIns = 1'b1;
        tick();
        idle();
    endtask

    // Build a 16-bit constant in register r: low byte via LI=0, then the high
    // byte via LI=1, which concatenates with r's current low byte.
    task automatic write_reg(input logic [2:0] r, input logic [15:0] val);
        load_ir({5'b00000, r, val[7:0]});
        dif.ALUorNot = 1'b1; dif.PCplus1orWB = 1'b1;
        tick(); tick();
        dif.WE_RF = 1'b1;
        tick();
        load_ir({5'b00000, r, val[15:8]});
        dif.RBresource = 1'b1; dif.LI = 1'b1;
        dif.ALUorNot = 1'b1; dif.PCplus1orWB = 1'b1;
        tick(); tick();
        dif.WE_RF = 1'b1;
        tick();
        idle();
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        checks = 0;
        errors = 0;
        Rst    = 1'b0;

        mem_tbl[0] = '{8'h00, 16'h0002};
        mem_tbl[1] = '{8'h01, 16'h0408};
        mem_tbl[2] = '{8'h02, 16'h0010};
        mem_tbl[3] = '{8'h03, 16'h0001};
        mem_tbl[4] = '{8'h0A, 16'h006A};

        // PC=4 and IR=0488: branch offset 0x88=-120, jump offset 0x488=-888, A=R4=006A
        npc_tbl[0] = '{1'b1, 2'b00, 16'hFF8C};
        npc_tbl[1] = '{1'b1, 2'b10, 16'hFF8C};
        npc_tbl[2] = '{1'b0, 2'b00, 16'h0005};
        npc_tbl[3] = '{1'b0, 2'b01, 16'hFC8C};
        npc_tbl[4] = '{1'b0, 2'b10, 16'h006A};
        npc_tbl[5] = '{1'b0, 2'b11, 16'h0005};

        // Rows 1 and 2 use Flag, carrying C from the row before (1 then 0).
        alu_tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 3'b011};
        alu_tbl[1] = '{16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0003, 3'b000};
        alu_tbl[2] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 3'b001};
        alu_tbl[3] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 3'b100};
        alu_tbl[4] = '{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 3'b001};
        alu_tbl[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 3'b000};
        alu_tbl[6] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0000, 3'b011};
        alu_tbl[7] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 3'b100};

        idle();
        do_reset();
        check("rst_pc",        dif.OutPC, 16'h0000);
        check("rst_psw",       {13'h0, dif.PSW_NZC}, 16'h0000);
        check("rst_outr",      dif.OutR, 16'h0000);
        check("rst_opcode",    {11'h0, dif.opcode}, 16'h0000);
        check("rst_aluopcode", {14'h0, dif.ALUopcode}, 16'h0000);
        check("rst_nextpc",    dif.OutNextPC, 16'h0001);

        // Memory load and readback through the bench port.
        dif.TBorNot = 1'b1;
        dif.Tb_MEMWE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dif.Tb_MEMAddr = mem_tbl[i].addr;
            dif.Tb_MEMData = mem_tbl[i].data;
            tick();
        end
        dif.Tb_MEMWE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dif.Tb_MEMAddr = mem_tbl[i].addr;
            #1;
            check("mem_readback", dif.OutM, mem_tbl[i].data);
        end

        // Reset must override Buff_PC and leave memory alone.
        idle();
        dif.Buff_PC = 1'b1;
        dif.Jump    = 2'b01;
        do_reset();
        idle();
        #1;
        check("rst_overrides_pc", dif.OutPC, 16'h0000);
        dif.TBorNot = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dif.Tb_MEMAddr = mem_tbl[i].addr;
            #1;
            check("mem_after_rst", dif.OutM, mem_tbl[i].data);
        end

        // Every register reads zero after reset.
        for (int i = 0; i < 8; i++) begin
            load_ir({8'h00, 3'(i), 5'b00000});
            check("rf_cleared", dif.OutR, 16'h0000);
        end

        do_reset();
        idle();
        #1;

        // LLI 0x0002: R0 <= 0002, PC <= 1.
        dif.Buff_MEMIns = 1'b1;
        tick();
        idle();
        dif.ALUorNot = 1'b1; dif.PCplus1orWB = 1'b1;
        tick(); tick(); tick();
        dif.WE_RF = 1'b1; dif.Buff_PC = 1'b1;
        tick();
        idle();
        #1;
        check("lli_pc", dif.OutPC, 16'h0001);
        check("lli_r0", dif.OutR, 16'h0002);

        // LDR 0x0408: ALUout = R0 + sext(8) = 000A, R4 <= MEM[0A] = 006A.
        dif.Buff_MEMIns = 1'b1;
        tick();
        idle();
        dif.oprandB = 1'b1;
        tick(); tick();
        dif.MEMresource = 1'b1;
        #1;
        check("ldr_aluout_addr", dif.OutM, 16'h006A);
        tick();
        dif.WBresource = 1'b1; dif.WE_RF = 1'b1; dif.Buff_PC = 1'b1;
        tick();
        idle();
        #1;
        check("ldr_pc", dif.OutPC, 16'h0002);

        // Fetch 0x0010: port A address IR[7:5]=0, so OutR shows R0.
        dif.Buff_MEMIns = 1'b1;
        tick();
        idle();
        #1;
        check("f10_outr",      dif.OutR, 16'h0002);
        check("f10_opcode",    {11'h0, dif.opcode}, 16'h0000);
        check("f10_aluopcode", {14'h0, dif.ALUopcode}, 16'h0000);
        dif.Buff_PC = 1'b1;
        tick();
        idle();
        #1;
        check("f10_pc", dif.OutPC, 16'h0003);

        // Fetch 0x0001.
        dif.Buff_MEMIns = 1'b1;
        tick();
        idle();
        #1;
        check("f01_aluopcode", {14'h0, dif.ALUopcode}, 16'h0001);
        dif.Buff_PC = 1'b1;
        tick();
        idle();
        #1;
        check("f01_pc",     dif.OutPC, 16'h0004);
        check("f01_nextpc", dif.OutNextPC, 16'h0005);

        // Next-PC selection with negative offsets; the extra tick moves R4 into A.
        load_ir(16'h0488);
        tick();
        check("r4_ldr_value", dif.OutR, 16'h006A);
        for (int i = 0; i < 6; i++) begin
            dif.Branch = npc_tbl[i].branch;
            dif.Jump   = npc_tbl[i].jump;
            #1;
            check("next_pc", dif.OutNextPC, npc_tbl[i].npc);
        end
        idle();
        dif.Jump = 2'b01; dif.Buff_PC = 1'b1;
        tick();
        idle();
        #1;
        check("jump_taken_pc", dif.OutPC, 16'hFC8C);

        // ALU: R1 op R2 -> R3 via IR 0328, then read R3 through port A.
        for (int i = 0; i < 8; i++) begin
            write_reg(3'd1, alu_tbl[i].a);
            write_reg(3'd2, alu_tbl[i].b);
            load_ir(16'h0328);
            dif.ALUop = alu_tbl[i].op;
            dif.Flag  = alu_tbl[i].flag;
            tick();
            dif.Buff_PSW = 1'b1;
            tick();
            dif.Buff_PSW = 1'b0;
            tick();
            dif.WE_RF = 1'b1; dif.PCplus1orWB = 1'b1;
            tick();
            idle();
            #1;
            check("alu_psw", {13'h0, dif.PSW_NZC}, {13'h0, alu_tbl[i].nzc});
            load_ir(16'h0060);
            check("alu_result", dif.OutR, alu_tbl[i].res);
        end

        // MOV: R5 <= A latch (R1 = 7FFF from the last ALU row).
        load_ir(16'h0520);
        dif.ALUorNot = 1'b1; dif.LIorMOV = 1'b1; dif.PCplus1orWB = 1'b1;
        tick(); tick();
        dif.WE_RF = 1'b1;
        tick();
        load_ir(16'h00A0);
        check("mov_r5", dif.OutR, 16'h7FFF);

        // Link write: R6 <= PC+1 with PC = FC8C.
        load_ir(16'h0600);
        dif.WE_RF = 1'b1;
        tick();
        load_ir(16'h00C0);
        check("link_r6", dif.OutR, 16'hFC8D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
